// File: rtl/mesh_array_if.sv
// Point-to-point link between neighbouring mesh nodes: a one-cycle write strobe
// with its data word. The sender drives the master side and the receiving inbox samples the slave side.
interface mesh_array_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  vld;
  logic [DATA_WIDTH-1:0] data;

  modport master (output vld, output data);
  modport slave  (input  vld, input  data);
endinterface

// File: rtl/mesh_array.sv
// mesh_array: ROWS x COLS fabric of autonomous micro-cores with east/south links into neighbour inboxes.
// Define MESH_WRAP_EN for torus links; without it, sends off the mesh edge are discarded.

module mesh_cpu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           rom_data_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic [5:0]            pc_o,
  output logic [31:0]           instr_o,
  output logic                  instr_busy_o,
  output logic                  data_busy_o,
  output logic                  ID_LU_HAZ_SIG,
  output logic [3:0]            dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic                  send_vld_o,
  output logic                  send_south_o,
  output logic [DATA_WIDTH-1:0] send_data_o,
  output logic                  in_rd_o,
  output logic                  in_north_o
);
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_SEND = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;

  typedef enum logic [1:0] {S_FETCH, S_LOADUSE, S_EXEC, S_MEM} state_e;

  state_e                state_q, state_d;
  logic [5:0]            pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  logic [3:0]            addr_q, addr_d;
  logic                  lw_pend_q, lw_pend_d;
  logic [2:0]            lw_rd_q, lw_rd_d;
  logic [DATA_WIDTH-1:0] rf_q [8];

  logic                  rf_we;
  logic [2:0]            rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;

  logic [3:0]                   op;
  logic [2:0]                   rd, rs1, rs2;
  logic signed [DATA_WIDTH-1:0] imm_sx, rs1_val, rs2_val, sum_ri, sum_rr;

  assign op      = instr_q[31:28];
  assign rd      = instr_q[27:25];
  assign rs1     = instr_q[24:22];
  assign rs2     = instr_q[21:19];
  assign imm_sx  = {{(DATA_WIDTH-16){instr_q[15]}}, instr_q[15:0]};
  assign rs1_val = (rs1 == 3'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 3'd0) ? '0 : rf_q[rs2];
  assign sum_ri  = rs1_val + imm_sx;
  assign sum_rr  = rs1_val + rs2_val;

  assign pc_o         = pc_q;
  assign instr_o      = instr_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = rs2_val;
  assign send_data_o  = rs2_val;
  assign send_south_o = instr_q[0];
  assign in_north_o   = instr_q[0];

  logic unused_bits;
  assign unused_bits = ^{instr_q[18:16], sum_ri[DATA_WIDTH-1:4]};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    addr_d        = addr_q;
    lw_pend_d     = lw_pend_q;
    lw_rd_d       = lw_rd_q;
    rf_we         = 1'b0;
    rf_wa         = rd;
    rf_wd         = '0;
    dmem_we_o     = 1'b0;
    send_vld_o    = 1'b0;
    in_rd_o       = 1'b0;
    instr_busy_o  = 1'b0;
    data_busy_o   = 1'b0;
    ID_LU_HAZ_SIG = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        instr_busy_o = !rst;
        instr_d      = rom_data_i;
        // Stall one cycle when the fetched word reads the register the previous LW is loading.
        if (lw_pend_q && (rom_data_i[24:22] == lw_rd_q || rom_data_i[21:19] == lw_rd_q))
          state_d = S_LOADUSE;
        else
          state_d = S_EXEC;
      end
      S_LOADUSE: begin
        ID_LU_HAZ_SIG = !rst;
        state_d       = S_EXEC;
      end
      S_EXEC: begin
        state_d   = S_FETCH;
        pc_d      = pc_q + 6'd4;
        lw_pend_d = 1'b0;
        case (op)
          OP_ADDI: begin
            rf_we = 1'b1;
            rf_wd = sum_ri;
          end
          OP_ADD: begin
            rf_we = 1'b1;
            rf_wd = sum_rr;
          end
          OP_LW, OP_SW: begin
            addr_d  = sum_ri[3:0];
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          OP_SEND: send_vld_o = !rst;
          OP_IN: begin
            in_rd_o = !rst;
            rf_we   = 1'b1;
            rf_wd   = in_data_i;
          end
          OP_JMP:  pc_d = {instr_q[3:0], 2'b00};
          default: ;
        endcase
      end
      S_MEM: begin
        data_busy_o = !rst;
        state_d     = S_FETCH;
        pc_d        = pc_q + 6'd4;
        lw_pend_d   = (op == OP_LW);
        lw_rd_d     = rd;
        if (op == OP_LW) begin
          rf_we = 1'b1;
          rf_wd = dmem_rdata_i;
        end else begin
          dmem_we_o = !rst;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      addr_q    <= '0;
      lw_pend_q <= 1'b0;
      lw_rd_q   <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      lw_pend_q <= lw_pend_d;
      lw_rd_q   <= lw_rd_d;
      if (rf_we && rf_wa != 3'd0) rf_q[rf_wa] <= rf_wd;
    end
  end
endmodule

module mesh_node #(
  parameter int DATA_WIDTH = 32,
  parameter int NODE_ID    = 0
) (
  input  logic         clk,
  input  logic         rst,
  mesh_array_if.master east_o,
  mesh_array_if.master south_o,
  mesh_array_if.slave  west_i,
  mesh_array_if.slave  north_i
);
  localparam logic [15:0] NODE_IMM = 16'(NODE_ID);

  logic [5:0]            pc;
  logic [31:0]           instruction;
  logic                  instr_mem_busywait;
  logic                  data_mem_busywait;

  logic [31:0]           rom_data;
  logic [3:0]            dmem_addr;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  send_vld, send_south, in_rd, in_north;
  logic [DATA_WIDTH-1:0] send_data, in_data;

  logic [DATA_WIDTH-1:0] dmem_q [16];
  logic [DATA_WIDTH-1:0] inbox_w_q, inbox_n_q;
  logic                  inbox_w_vld_q, inbox_n_vld_q;

  // Fields: op[31:28] rd[27:25] rs1[24:22] rs2[21:19] pad[18:16] imm[15:0]
  function automatic logic [31:0] rom_word(input logic [3:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      4'd0: w = {4'd1, 3'd1, 3'd0, 3'd0, 3'd0, NODE_IMM};
      4'd1: w = {4'd1, 3'd2, 3'd2, 3'd0, 3'd0, 16'd1};
      4'd2: w = {4'd4, 3'd0, 3'd0, 3'd2, 3'd0, 16'd0};
      4'd3: w = {4'd3, 3'd3, 3'd0, 3'd0, 3'd0, 16'd0};
      4'd4: w = {4'd2, 3'd4, 3'd3, 3'd1, 3'd0, 16'd0};
      4'd5: w = {4'd5, 3'd0, 3'd0, 3'd4, 3'd0, 16'd0};
      4'd6: w = {4'd5, 3'd0, 3'd0, 3'd4, 3'd0, 16'd1};
      4'd7: w = {4'd6, 3'd5, 3'd0, 3'd0, 3'd0, 16'd0};
      4'd8: w = {4'd7, 3'd0, 3'd0, 3'd0, 3'd0, 16'd1};
      default: w = '0;
    endcase
    return w;
  endfunction

  assign rom_data = rom_word(pc[5:2]);
  assign in_data  = in_north ? inbox_n_q : inbox_w_q;

  mesh_cpu #(.DATA_WIDTH(DATA_WIDTH)) CPU (
    .clk          (clk),
    .rst          (rst),
    .rom_data_i   (rom_data),
    .dmem_rdata_i (dmem_q[dmem_addr]),
    .in_data_i    (in_data),
    .pc_o         (pc),
    .instr_o      (instruction),
    .instr_busy_o (instr_mem_busywait),
    .data_busy_o  (data_mem_busywait),
    .ID_LU_HAZ_SIG(),
    .dmem_addr_o  (dmem_addr),
    .dmem_we_o    (dmem_we),
    .dmem_wdata_o (dmem_wdata),
    .send_vld_o   (send_vld),
    .send_south_o (send_south),
    .send_data_o  (send_data),
    .in_rd_o      (in_rd),
    .in_north_o   (in_north)
  );

  assign east_o.vld   = send_vld && !send_south;
  assign east_o.data  = send_data;
  assign south_o.vld  = send_vld && send_south;
  assign south_o.data = send_data;

  logic unused_probe;
  assign unused_probe = ^{pc[1:0], instruction, instr_mem_busywait, data_mem_busywait};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) dmem_q[i] <= '0;
    end else if (dmem_we) begin
      dmem_q[dmem_addr] <= dmem_wdata;
    end
  end

  // An arriving word beats a same-cycle IN, so the inbox stays valid with the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inbox_w_q     <= '0;
      inbox_w_vld_q <= 1'b0;
      inbox_n_q     <= '0;
      inbox_n_vld_q <= 1'b0;
    end else begin
      if (west_i.vld) begin
        inbox_w_q     <= west_i.data;
        inbox_w_vld_q <= 1'b1;
      end else if (in_rd && !in_north) begin
        inbox_w_vld_q <= 1'b0;
      end
      if (north_i.vld) begin
        inbox_n_q     <= north_i.data;
        inbox_n_vld_q <= 1'b1;
      end else if (in_rd && in_north) begin
        inbox_n_vld_q <= 1'b0;
      end
    end
  end
endmodule

module mesh_array #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst
);
  localparam int N = ROWS * COLS;

  logic [N-1:0]                 east_vld, south_vld;
  logic [N-1:0][DATA_WIDTH-1:0] east_dat, south_dat;

  for (genvar r = 0; r < ROWS; r++) begin : ROW_LOOP
    for (genvar c = 0; c < COLS; c++) begin : COL_LOOP
      localparam int IDX = r * COLS + c;

      mesh_array_if #(.DATA_WIDTH(DATA_WIDTH)) east_if  ();
      mesh_array_if #(.DATA_WIDTH(DATA_WIDTH)) south_if ();
      mesh_array_if #(.DATA_WIDTH(DATA_WIDTH)) west_if  ();
      mesh_array_if #(.DATA_WIDTH(DATA_WIDTH)) north_if ();

      assign east_vld[IDX]  = east_if.vld;
      assign east_dat[IDX]  = east_if.data;
      assign south_vld[IDX] = south_if.vld;
      assign south_dat[IDX] = south_if.data;

      if (c > 0) begin : G_WEST
        assign west_if.vld  = east_vld[IDX-1];
        assign west_if.data = east_dat[IDX-1];
      end else begin : G_WEST_EDGE
`ifdef MESH_WRAP_EN
        assign west_if.vld  = east_vld[IDX+COLS-1];
        assign west_if.data = east_dat[IDX+COLS-1];
`else
        assign west_if.vld  = 1'b0;
        assign west_if.data = '0;
`endif
      end

      if (r > 0) begin : G_NORTH
        assign north_if.vld  = south_vld[IDX-COLS];
        assign north_if.data = south_dat[IDX-COLS];
      end else begin : G_NORTH_EDGE
`ifdef MESH_WRAP_EN
        assign north_if.vld  = south_vld[(ROWS-1)*COLS+c];
        assign north_if.data = south_dat[(ROWS-1)*COLS+c];
`else
        assign north_if.vld  = 1'b0;
        assign north_if.data = '0;
`endif
      end

      mesh_node #(
        .DATA_WIDTH(DATA_WIDTH),
        .NODE_ID   (IDX)
      ) u_node (
        .clk    (clk),
        .rst    (rst),
        .east_o (east_if.master),
        .south_o(south_if.master),
        .west_i (west_if.slave),
        .north_i(north_if.slave)
      );
    end
  end

  // Edge-node outputs have no receiver unless the mesh wraps.
  logic unused_edge;
  assign unused_edge = ^{east_vld, south_vld, east_dat, south_dat};
endmodule

// File: tb/tb_mesh_array.sv
// Bench for mesh_array: instruction-level timing model of every node, checked each cycle,
// with randomly placed mid-run resets.
module tb_mesh_array;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 32;
  localparam int NN   = ROWS * COLS;
`ifdef MESH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mesh_array #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst(rst)
  );

  mesh_array_if #(.DATA_WIDTH(DW)) mon_if ();
  assign mon_if.vld  = dut.ROW_LOOP[0].COL_LOOP[0].u_node.inbox_w_vld_q;
  assign mon_if.data = dut.ROW_LOOP[0].COL_LOOP[0].u_node.inbox_w_q;

  logic [5:0]    pc_p  [NN];
  logic [31:0]   ins_p [NN];
  logic          ib_p  [NN];
  logic          db_p  [NN];
  logic          hz_p  [NN];
  logic [DW-1:0] rf_p  [NN][8];
  logic [DW-1:0] dm_p  [NN];
  logic [DW-1:0] iw_p  [NN];
  logic          iwv_p [NN];
  logic [DW-1:0] inn_p [NN];
  logic          inv_p [NN];

  for (genvar gr = 0; gr < ROWS; gr++) begin : G_R
    for (genvar gc = 0; gc < COLS; gc++) begin : G_C
      localparam int GN = gr * COLS + gc;
      assign pc_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.pc;
      assign ins_p[GN] = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.instruction;
      assign ib_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.instr_mem_busywait;
      assign db_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.data_mem_busywait;
      assign hz_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.CPU.ID_LU_HAZ_SIG;
      assign dm_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.dmem_q[0];
      assign iw_p[GN]  = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.inbox_w_q;
      assign iwv_p[GN] = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.inbox_w_vld_q;
      assign inn_p[GN] = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.inbox_n_q;
      assign inv_p[GN] = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.inbox_n_vld_q;
      for (genvar gi = 0; gi < 8; gi++) begin : G_RF
        assign rf_p[GN][gi] = dut.ROW_LOOP[gr].COL_LOOP[gc].u_node.CPU.rf_q[gi];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], 3'b000, imm[15:0]};
  endfunction

  // Program as assembled from the listing; word 0 carries the node id.
  function automatic logic [31:0] prog(input int n, input int w);
    case (w)
      0: return enc(1, 1, 0, 0, n);
      1: return enc(1, 2, 2, 0, 1);
      2: return enc(4, 0, 0, 2, 0);
      3: return enc(3, 3, 0, 0, 0);
      4: return enc(2, 4, 3, 1, 0);
      5: return enc(5, 0, 0, 4, 0);
      6: return enc(5, 0, 0, 4, 1);
      7: return enc(6, 5, 0, 0, 0);
      8: return enc(7, 0, 0, 0, 1);
      default: return 32'd0;
    endcase
  endfunction

  // Cycles per instruction: 2 plain, 3 for SW/LW, 3 for the ADD that stalls on the LW.
  function automatic int cost(input int w);
    return (w == 2 || w == 3 || w == 4) ? 3 : 2;
  endfunction

  // For cycle t after reset release: active word w, its fetch cycle s, and pass number k.
  task automatic locate(input int t, output int w, output int s, output int k);
    int ww, ss;
    if (t < 21) begin
      k = 1; ww = 0; ss = 0;
    end else begin
      k = (t - 21) / 19 + 2; ww = 1; ss = 21 + (k - 2) * 19;
    end
    while (ss + cost(ww) <= t) begin
      ss += cost(ww);
      ww++;
    end
    w = ww;
    s = ss;
  endtask

  task automatic check_node(input int t, input int n);
    int w, s, k, r, c, wid, nid, p;
    bit has_w, has_n;
    logic [31:0] e;
    locate(t, w, s, k);
    r     = n / COLS;
    c     = n % COLS;
    has_w = (c > 0) || WRAP;
    wid   = (c > 0) ? n - 1 : r * COLS + COLS - 1;
    has_n = (r > 0) || WRAP;
    nid   = (r > 0) ? n - COLS : (ROWS - 1) * COLS + c;

    chk($sformatf("n%0d pc t%0d", n, t), 32'(pc_p[n]), 32'(4 * w));
    if (t != s)       e = prog(n, w);
    else if (w == 0)  e = 32'd0;
    else if (w == 1 && k > 1) e = prog(n, 8);
    else              e = prog(n, w - 1);
    chk($sformatf("n%0d instr t%0d", n, t), ins_p[n], e);
    chk($sformatf("n%0d ibusy t%0d", n, t), 32'(ib_p[n]), 32'(t == s));
    chk($sformatf("n%0d dbusy t%0d", n, t), 32'(db_p[n]), 32'((w == 2 || w == 3) && t == s + 2));
    chk($sformatf("n%0d haz t%0d", n, t), 32'(hz_p[n]), 32'(w == 4 && t == s + 1));

    chk($sformatf("n%0d r1 t%0d", n, t), rf_p[n][1], (k > 1 || w > 0) ? 32'(n) : 32'd0);
    chk($sformatf("n%0d r2 t%0d", n, t), rf_p[n][2], 32'((w > 1) ? k : k - 1));
    chk($sformatf("n%0d ram0 t%0d", n, t), dm_p[n], 32'((w > 2) ? k : k - 1));
    chk($sformatf("n%0d r3 t%0d", n, t), rf_p[n][3], 32'((w > 3) ? k : k - 1));
    p = (w > 4) ? k : k - 1;
    chk($sformatf("n%0d r4 t%0d", n, t), rf_p[n][4], (p > 0) ? 32'(p + n) : 32'd0);
    p = (w > 5) ? k : k - 1;
    chk($sformatf("n%0d inbox_w t%0d", n, t), iw_p[n], (has_w && p > 0) ? 32'(p + wid) : 32'd0);
    chk($sformatf("n%0d inbox_w_vld t%0d", n, t), 32'(iwv_p[n]), 32'(has_w && (w == 6 || w == 7)));
    p = (w > 6) ? k : k - 1;
    chk($sformatf("n%0d inbox_n t%0d", n, t), inn_p[n], (has_n && p > 0) ? 32'(p + nid) : 32'd0);
    chk($sformatf("n%0d inbox_n_vld t%0d", n, t), 32'(inv_p[n]), 32'(has_n && p > 0));
    p = (w > 7) ? k : k - 1;
    chk($sformatf("n%0d r5 t%0d", n, t), rf_p[n][5], (has_w && p > 0) ? 32'(p + wid) : 32'd0);
  endtask

  task automatic check_reset(input string tag);
    for (int n = 0; n < NN; n++) begin
      chk($sformatf("%s n%0d pc", tag, n), 32'(pc_p[n]), 32'd0);
      chk($sformatf("%s n%0d instr", tag, n), ins_p[n], 32'd0);
      chk($sformatf("%s n%0d ibusy", tag, n), 32'(ib_p[n]), 32'd0);
      chk($sformatf("%s n%0d dbusy", tag, n), 32'(db_p[n]), 32'd0);
      chk($sformatf("%s n%0d haz", tag, n), 32'(hz_p[n]), 32'd0);
      chk($sformatf("%s n%0d r2", tag, n), rf_p[n][2], 32'd0);
      chk($sformatf("%s n%0d r4", tag, n), rf_p[n][4], 32'd0);
      chk($sformatf("%s n%0d ram0", tag, n), dm_p[n], 32'd0);
      chk($sformatf("%s n%0d inbox_w_vld", tag, n), 32'(iwv_p[n]), 32'd0);
      chk($sformatf("%s n%0d inbox_n_vld", tag, n), 32'(inv_p[n]), 32'd0);
    end
  endtask

  // Release reset and follow every node for ncyc cycles against the model.
  task automatic run(input int ncyc);
    int hz_seen;
    hz_seen = 0;
    rst = 1'b0;
    #1;
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) @(negedge clk);
      for (int n = 0; n < NN; n++) check_node(t, n);
      if (t < 21) hz_seen += int'(hz_p[NN-1]);
      if (t == 21) begin
        chk("first pass hazard cycles", 32'(hz_seen), 32'd1);
        chk("node00 west link", mon_if.data, WRAP ? 32'd2 : 32'd0);
        chk("node11 r4 first pass", rf_p[NN-1][4], 32'd4);
      end
    end
  endtask

  // Assert reset somewhere mid-instruction and confirm the whole fabric clears.
  task automatic mid_reset(input int it);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int n = 0; n < NN; n++) begin
      chk($sformatf("rst%0d n%0d ibusy gated", it, n), 32'(ib_p[n]), 32'd0);
      chk($sformatf("rst%0d n%0d dbusy gated", it, n), 32'(db_p[n]), 32'd0);
      chk($sformatf("rst%0d n%0d haz gated", it, n), 32'(hz_p[n]), 32'd0);
    end
    repeat (2) @(negedge clk);
    check_reset($sformatf("rst%0d", it));
  endtask

  initial begin
    int ncyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("por");
    run(100);
    for (int it = 0; it < 4; it++) begin
      mid_reset(it);
      ncyc = int'($urandom_range(90, 3));
      run(ncyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
